// File: rtl/truth_table_extractor_if.sv
// Sweep control and gate-under-test bundle for truth_table_extractor.
// The slave side is the extractor; the master side is the harness and gate.
interface truth_table_extractor_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic                 abort;
  logic [N_IN-1:0]      dut_in;
  logic                 dut_out;
  logic                 busy;
  logic                 done;
  logic [(1<<N_IN)-1:0] tt_code;
  logic                 glitch;

  modport slave (
    input  start,
    input  abort,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output tt_code,
    output glitch
  );

  modport master (
    output start,
    output abort,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  tt_code,
    input  glitch
  );
endinterface

// File: rtl/truth_table_extractor.sv
// Sweeps every input row of a combinational gate, majority-votes
// the sampled output per row and publishes the hex truth-table code.
module truth_table_extractor #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input logic                    clk,
  input logic                    rst,
  truth_table_extractor_if.slave bus
);

  localparam int W  = 1 << N_IN;
  localparam int CW = $clog2(SETTLE_CYCLES + SAMPLES);
  localparam int OW = $clog2(SAMPLES + 1);
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t          state_q;
  logic [N_IN:0]   row_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   ones_q;
  logic [W-1:0]    shadow_q;
  logic [W-1:0]    tt_q;
  logic [N_IN-1:0] din_q;
  logic            busy_q;
  logic            done_q;
  logic            glitch_q;

  logic [OW-1:0]   ones_d;
  logic [N_IN:0]   row_d;
  logic [N_IN-1:0] sidx;
  logic            last_smp;
  logic            last_row;
  logic            res;
  logic            mixed;

  // ones_d includes the sample being taken on this edge
  assign ones_d   = ones_q + OW'(bus.dut_out);
  assign row_d    = row_q + (N_IN+1)'(1);
  assign sidx     = ~row_q[N_IN-1:0];
  assign last_smp = (cnt_q == CW'(SAMPLES - 1));
  assign last_row = (row_q == LAST);
  assign res      = (ones_d > OW'(SAMPLES / 2));
  assign mixed    = (ones_d != '0) && (ones_d != OW'(SAMPLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
      shadow_q <= '0;
      tt_q     <= '0;
      din_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        state_q <= IDLE;
        din_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // a start coinciding with the done pulse is dropped
            if (bus.start && !bus.abort && !done_q) begin
              state_q  <= SETTLE;
              row_q    <= '0;
              din_q    <= '0;
              cnt_q    <= '0;
              ones_q   <= '0;
              shadow_q <= '0;
              glitch_q <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
          SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
              cnt_q   <= '0;
              ones_q  <= '0;
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          SAMPLE: begin
            if (last_smp) begin
              cnt_q          <= '0;
              ones_q         <= '0;
              shadow_q[sidx] <= res;
              if (mixed) glitch_q <= 1'b1;
              if (last_row) begin
                state_q <= DONE;
              end else begin
                row_q   <= row_d;
                din_q   <= row_d[N_IN-1:0];
                state_q <= SETTLE;
              end
            end else begin
              cnt_q  <= cnt_q + CW'(1);
              ones_q <= ones_d;
            end
          end
          DONE: begin
            tt_q    <= shadow_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.dut_in  = din_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tt_code = tt_q;
  assign bus.glitch  = glitch_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: vector table, random gates with
// sample noise against a row-majority model, and corner sequences.
module tb_truth_table_extractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic inj = 1'b0;
  logic [7:0] gate = 8'h00;

  always #5 clk = ~clk;

  truth_table_extractor_if #(.N_IN(3)) a ();
  truth_table_extractor_if #(.N_IN(2)) b ();

  // gate model: output bit for row r lives at code bit 7-r
  assign a.dut_out = gate[~a.dut_in] ^ inj;
  assign b.dut_out = &b.dut_in;

  truth_table_extractor #(.N_IN(3)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  truth_table_extractor #(.N_IN(2)) u_b (
    .clk (clk),
    .rst (rst2),
    .bus (b.slave)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  code;
    logic [63:0] fl;
    logic [7:0]  ec;
    logic        eg;
  } vec_t;

  // fl bit e flips dut_out as seen at clock edge e after the start edge
  function automatic void ref_sweep(input logic [7:0] code,
                                    input logic [63:0] fl,
                                    output logic [7:0] ec,
                                    output logic eg);
    int ones;
    ec = '0;
    eg = 1'b0;
    for (int r = 0; r < 8; r++) begin
      ones = 0;
      for (int s = 0; s < 3; s++)
        ones += int'(code[7-r] ^ fl[r*7 + 4 + s + 1]);
      ec[7-r] = (ones >= 2);
      if (ones > 0 && ones < 3) eg = 1'b1;
    end
  endfunction

  task automatic sweep(input string nm, input logic [7:0] code,
                       input logic [63:0] fl, input logic [7:0] ec,
                       input logic eg);
    int dn, lat, sb;
    logic [7:0] old;
    gate = code;
    old = a.tt_code;
    dn = 0;
    lat = -1;
    sb = 0;
    @(negedge clk);
    a.start = 1'b1;
    @(posedge clk);
    #1;
    a.start = 1'b0;
    inj = fl[1];
    for (int e = 0; e < 100; e++) begin
      @(negedge clk);
      if (a.done) begin
        dn++;
        if (lat < 0) lat = e;
      end
      if (e <= 55 && a.dut_in != 3'(e / 7)) sb++;
      if (e <= 56 && !a.busy) sb++;
      if (e == 57 && a.busy) sb++;
      if (e < 57 && a.tt_code != old) sb++;
      if (e >= 60) break;
      @(posedge clk);
      #1;
      inj = (e + 2 <= 56) ? fl[e+2] : 1'b0;
    end
    inj = 1'b0;
    chk({nm, " latency"}, lat, 57);
    chk({nm, " done_count"}, dn, 1);
    chk({nm, " row_sequence"}, sb, 0);
    chk({nm, " tt_code"}, int'(a.tt_code), int'(ec));
    chk({nm, " glitch"}, int'(a.glitch), int'(eg));
  endtask

  vec_t vt[6];
  logic [7:0] rc, rec;
  logic [63:0] rfl;
  logic reg_;
  int n, p1, p2, np, ttok, found;

  initial begin
    vt[0] = '{8'h59, 64'h0, 8'h59, 1'b0};
    vt[1] = '{8'h00, 64'h0, 8'h00, 1'b0};
    vt[2] = '{8'hFF, 64'h0, 8'hFF, 1'b0};
    vt[3] = '{8'h59, 64'h1000, 8'h59, 1'b1};
    vt[4] = '{8'hA5, 64'h60, 8'h25, 1'b1};
    vt[5] = '{8'h00, 64'h01C0000000000000, 8'h01, 1'b0};

    a.start = 1'b0;
    a.abort = 1'b0;
    b.start = 1'b0;
    b.abort = 1'b0;

    #3;
    chk("reset dut_in", int'(a.dut_in), 0);
    chk("reset busy", int'(a.busy), 0);
    chk("reset done", int'(a.done), 0);
    chk("reset tt_code", int'(a.tt_code), 0);
    chk("reset glitch", int'(a.glitch), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      sweep($sformatf("vec%0d", i), vt[i].code, vt[i].fl, vt[i].ec, vt[i].eg);

    for (int i = 0; i < 6; i++) begin
      rc = 8'($urandom);
      rfl = '0;
      for (int e = 1; e <= 56; e++)
        if ($urandom_range(0, 7) == 0) rfl[e] = 1'b1;
      ref_sweep(rc, rfl, rec, reg_);
      sweep($sformatf("rnd%0d", i), rc, rfl, rec, reg_);
    end

    sweep("pre_abort", 8'h59, 64'h0, 8'h59, 1'b0);

    // abort on row 4
    @(negedge clk);
    a.start = 1'b1;
    @(posedge clk);
    #1;
    a.start = 1'b0;
    n = 0;
    while (n < 100 && a.dut_in != 3'd4) begin
      @(negedge clk);
      n++;
    end
    chk("abort reach_row4", int'(a.dut_in), 4);
    @(negedge clk);
    a.abort = 1'b1;
    @(posedge clk);
    #1;
    a.abort = 1'b0;
    chk("abort busy", int'(a.busy), 0);
    chk("abort dut_in", int'(a.dut_in), 0);
    n = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (a.done) n++;
    end
    chk("abort no_done", n, 0);
    chk("abort tt_code", int'(a.tt_code), 8'h59);

    // abort and start together while idle
    @(negedge clk);
    a.start = 1'b1;
    a.abort = 1'b1;
    @(posedge clk);
    #1;
    a.start = 1'b0;
    a.abort = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a.busy) n++;
    end
    chk("abort_start idle", n, 0);

    // start held high: back-to-back sweeps
    gate = 8'h59;
    @(negedge clk);
    a.start = 1'b1;
    p1 = -1;
    p2 = -1;
    np = 0;
    ttok = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      if (a.done) begin
        np++;
        if (a.tt_code == 8'h59) ttok++;
        if (p1 < 0) p1 = c;
        else if (p2 < 0) p2 = c;
      end
    end
    a.start = 1'b0;
    chk("b2b pulses", np, 2);
    chk("b2b first", p1, 57);
    chk("b2b gap_ok", int'(p2 - p1 >= 58), 1);
    chk("b2b tt_code", ttok, np);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (a.done) found = 1;
    end
    chk("b2b drain", found, 1);

    // N_IN=2 AND gate with reset mid-sweep
    @(negedge clk);
    b.start = 1'b1;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("n2 busy_mid", int'(b.busy), 1);
    rst2 = 1'b1;
    #1;
    chk("n2 rst busy", int'(b.busy), 0);
    chk("n2 rst dut_in", int'(b.dut_in), 0);
    chk("n2 rst tt_code", int'(b.tt_code), 0);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    @(negedge clk);
    b.start = 1'b1;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    n = 0;
    p1 = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (b.done) begin
        n++;
        if (p1 < 0) p1 = c;
      end
    end
    chk("n2 done_count", n, 1);
    chk("n2 latency", p1, 29);
    chk("n2 tt_code", int'(b.tt_code), 1);
    chk("n2 glitch", int'(b.glitch), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
